// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer.
// Build option: FETCH_PERF_EN adds the fetch/stall counters.
package fetch_pkg;

  localparam int FETCH_AW    = 8;
  localparam int FETCH_DW    = 32;
  localparam int FETCH_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_DW-1:0] instr;
    logic [FETCH_AW-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetched words; flush beats push and pop.
// Build option: none (FETCH_PERF_EN lives in fetch_ctrl).
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = FETCH_DEPTH,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  entry_t                 data_i,
  output entry_t                 head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_q;
  logic [PW-1:0]   rd_q;
  logic [CW-1:0]   cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PW'(1);
      if (pop_i)  rd_q <= rd_q + PW'(1);
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC, IDLE/RUN/HALT FSM, redirect flush, prefetch.
// Build option: FETCH_PERF_EN adds perf_fetch_o / perf_stall_o.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int            AW       = FETCH_AW,
  parameter int            DW       = FETCH_DW,
  parameter int            DEPTH    = FETCH_DEPTH,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          halt_i,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i,
  output logic [AW-1:0] pmem_addr_o,
  input  logic [DW-1:0] pmem_data_i,
  output logic          instr_valid_o,
  input  logic          instr_ready_i,
  output logic [DW-1:0] instr_o,
  output logic [AW-1:0] instr_pc_o,
`ifdef FETCH_PERF_EN
  output logic [15:0]   perf_fetch_o,
  output logic [15:0]   perf_stall_o,
`endif
  output logic          busy_o
);

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;

  fetch_state_e          state_q, state_d;
  logic [AW-1:0]         pc_q, pc_d;
  logic                  push, pop, flush;
  logic                  full, empty;
  logic [$clog2(DEPTH):0] count;
  entry_t                head, wdata;

  assign pop   = instr_valid_o & instr_ready_i;
  assign flush = redirect_i & (state_q != IDLE);
  assign push  = (state_q == RUN) & ~halt_i & ~redirect_i
               & (~full | pop);
  assign wdata = '{instr: pmem_data_i, pc: pc_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: if (start_i) begin
        state_d = RUN;
        pc_d    = RESET_PC;
      end
      RUN:  if (halt_i)  state_d = HALT;
      HALT: if (start_i) state_d = RUN;
      default: state_d = IDLE;
    endcase
    // Redirect overrides any increment; AW-bit wrap is intended.
    if (flush)     pc_d = redirect_pc_i;
    else if (push) pc_d = pc_q + AW'(1);
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (wdata),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign pmem_addr_o   = pc_q;
  assign instr_valid_o = (count != '0);
  assign instr_o       = empty ? '0 : head.instr;
  assign instr_pc_o    = empty ? '0 : head.pc;
  assign busy_o        = (state_q == RUN);

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_q, stall_cnt_q;
  logic        stall;

  assign stall = (state_q == RUN) & ~halt_i & ~redirect_i
               & full & ~pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push && fetch_cnt_q != 16'hFFFF)
        fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (stall && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign perf_fetch_o = fetch_cnt_q;
  assign perf_stall_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; pmem word = addr + 32'hA000.
// Build option: FETCH_PERF_EN also checks the perf counters.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        redir = 1'b0;
  logic [7:0]  redir_pc = 8'h00;
  logic [7:0]  addr;
  logic [31:0] pdata;
  logic        valid;
  logic        ready = 1'b0;
  logic [31:0] instr;
  logic [7:0]  ipc;
  logic        busy;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch, perf_stall;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign pdata = 32'hA000 + {24'h0, addr};

  fetch_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .start_i       (start),
    .halt_i        (halt),
    .redirect_i    (redir),
    .redirect_pc_i (redir_pc),
    .pmem_addr_o   (addr),
    .pmem_data_i   (pdata),
    .instr_valid_o (valid),
    .instr_ready_i (ready),
    .instr_o       (instr),
    .instr_pc_o    (ipc),
`ifdef FETCH_PERF_EN
    .perf_fetch_o  (perf_fetch),
    .perf_stall_o  (perf_stall),
`endif
    .busy_o        (busy)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    {start, halt, redir, ready} = '0;
    redir_pc = 8'h00;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({valid, busy, addr, ipc, instr} !== 50'h0) begin
      n_err++;
      $display("FAIL reset: v=%b b=%b a=%h pc=%h i=%h want all 0",
               valid, busy, addr, ipc, instr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    start = 1'b1;
    ready = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({busy, valid, addr} !== {1'b1, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL stream_start: b=%b v=%b a=%h want 1 0 00",
               busy, valid, addr);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({valid, ipc, instr} !== {1'b1, 8'(i), 32'hA000 + i}) begin
        n_err++;
        $display("FAIL stream[%0d]: v=%b pc=%h i=%h want 1 %h %h",
                 i, valid, ipc, instr, 8'(i), 32'hA000 + i);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({valid, ipc, addr} !== {1'b1, 8'h00, 8'h02}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: v=%b pc=%h a=%h want 1 00 02",
                 k, valid, ipc, addr);
      end
`ifdef FETCH_PERF_EN
      n_cmp++;
      if (perf_stall !== 16'(k) || perf_fetch !== 16'd2) begin
        n_err++;
        $display("FAIL perf[%0d]: stall=%0d fetch=%0d want %0d 2",
                 k, perf_stall, perf_fetch, k);
      end
`endif
      tick();
    end
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({valid, ipc} !== {1'b1, 8'(i)}) begin
        n_err++;
        $display("FAIL stall_resume[%0d]: v=%b pc=%h want 1 %h",
                 i, valid, ipc, 8'(i));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    start = 1'b1;
    ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    ready = 1'b0;
    tick();
    n_cmp++;
    if ({valid, ipc, addr} !== {1'b1, 8'h05, 8'h07}) begin
      n_err++;
      $display("FAIL redir_pre: v=%b pc=%h a=%h want 1 05 07",
               valid, ipc, addr);
    end
    redir = 1'b1;
    redir_pc = 8'h40;
    ready = 1'b1;
    tick();
    redir = 1'b0;
    n_cmp++;
    if ({valid, addr} !== {1'b0, 8'h40}) begin
      n_err++;
      $display("FAIL redir_bubble: v=%b a=%h want 0 40", valid, addr);
    end
    tick();
    n_cmp++;
    if ({valid, ipc, instr} !== {1'b1, 8'h40, 32'hA040}) begin
      n_err++;
      $display("FAIL redir_target: v=%b pc=%h i=%h want 1 40 0000a040",
               valid, ipc, instr);
    end
    tick();
    n_cmp++;
    if ({valid, ipc} !== {1'b1, 8'h41}) begin
      n_err++;
      $display("FAIL redir_next: v=%b pc=%h want 1 41", valid, ipc);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [4];
    exp_pc = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    do_reset();
    start = 1'b1;
    ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    redir = 1'b1;
    redir_pc = 8'hFE;
    tick();
    redir = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({valid, ipc, instr} !==
          {1'b1, exp_pc[i], 32'hA000 + {24'h0, exp_pc[i]}}) begin
        n_err++;
        $display("FAIL wrap[%0d]: v=%b pc=%h i=%h want 1 %h", i,
                 valid, ipc, instr, exp_pc[i]);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    do_reset();
    start = 1'b1;
    ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    ready = 1'b0;
    tick();
    n_cmp++;
    if ({valid, ipc, addr} !== {1'b1, 8'h08, 8'h0A}) begin
      n_err++;
      $display("FAIL halt_pre: v=%b pc=%h a=%h want 1 08 0a",
               valid, ipc, addr);
    end
    halt = 1'b1;
    ready = 1'b1;
    tick();
    halt = 1'b0;
    n_cmp++;
    if ({busy, valid, ipc, addr} !== {1'b0, 1'b1, 8'h09, 8'h0A}) begin
      n_err++;
      $display("FAIL halt_drain: b=%b v=%b pc=%h a=%h want 0 1 09 0a",
               busy, valid, ipc, addr);
    end
    tick();
    n_cmp++;
    if ({busy, valid, addr} !== {1'b0, 1'b0, 8'h0A}) begin
      n_err++;
      $display("FAIL halt_empty: b=%b v=%b a=%h want 0 0 0a",
               busy, valid, addr);
    end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({busy, valid, addr} !== {1'b1, 1'b0, 8'h0A}) begin
      n_err++;
      $display("FAIL halt_resume: b=%b v=%b a=%h want 1 0 0a",
               busy, valid, addr);
    end
    tick();
    n_cmp++;
    if ({valid, ipc, instr} !== {1'b1, 8'h0A, 32'hA00A}) begin
      n_err++;
      $display("FAIL halt_first: v=%b pc=%h i=%h want 1 0a 0000a00a",
               valid, ipc, instr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({valid, addr} !== {1'b1, 8'h02}) begin
      n_err++;
      $display("FAIL rmid_pre: v=%b a=%h want 1 02", valid, addr);
    end
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({valid, busy, addr, ipc} !== 18'h0) begin
      n_err++;
      $display("FAIL rmid_async: v=%b b=%b a=%h pc=%h want 0 0 00 00",
               valid, busy, addr, ipc);
    end
    tick();
    rst_ni = 1'b1;
    ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL rmid_idle: v=%b b=%b want 0 0", valid, busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++;
    if ({valid, ipc, instr} !== {1'b1, 8'h00, 32'hA000}) begin
      n_err++;
      $display("FAIL rmid_restart: v=%b pc=%h i=%h want 1 00 0000a000",
               valid, ipc, instr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
